// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, debug writes queue in a FIFO.
// Define REGARB_STARVE_EN to add the starvation counter and STALL state that raise stall_req_o.
module regfile_wr_arb #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          wb_we_i,
   input  logic [4:0]                    wb_wr_i,
   input  logic [31:0]                   wb_wd_i,
   input  logic                          dbg_valid_i,
   output logic                          dbg_ready_o,
   input  logic [4:0]                    dbg_wr_i,
   input  logic [31:0]                   dbg_wd_i,
   output logic                          rf_we_o,
   output logic [4:0]                    rf_wr_o,
   output logic [31:0]                   rf_wd_o,
   output logic [$clog2(FIFO_DEPTH):0]   dbg_cnt_o,
   output logic                          stall_req_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;

   logic [4:0]    r_fifo_wr [FIFO_DEPTH];
   logic [31:0]   r_fifo_wd [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_state, w_state_nxt;
   logic          w_busy, w_ready, w_push, w_nempty, w_discard, w_issue, w_pop;
   logic [4:0]    w_head_wr;
   logic [31:0]   w_head_wd;

   assign w_busy    = wb_we_i && (wb_wr_i != 5'd0);
   assign w_ready   = (r_cnt < CW'(FIFO_DEPTH));
   assign w_push    = dbg_valid_i && w_ready;
   assign w_nempty  = (r_cnt != '0);
   assign w_head_wr = r_fifo_wr[r_rptr];
   assign w_head_wd = r_fifo_wd[r_rptr];
   // x0 entries are dropped regardless of slot usage; real entries wait for a free slot
   assign w_discard = w_nempty && (w_head_wr == 5'd0);
   assign w_issue   = w_nempty && (w_head_wr != 5'd0) && !w_busy;
   assign w_pop     = w_discard || w_issue;
   assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

   assign dbg_ready_o = w_ready;
   assign dbg_cnt_o   = r_cnt;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_wr[r_wptr] <= dbg_wr_i;
         r_fifo_wd[r_wptr] <= dbg_wd_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rf_we_o <= 1'b0;
         rf_wr_o <= '0;
         rf_wd_o <= '0;
      end else if (w_busy) begin
         rf_we_o <= 1'b1;
         rf_wr_o <= wb_wr_i;
         rf_wd_o <= wb_wd_i;
      end else if (w_issue) begin
         rf_we_o <= 1'b1;
         rf_wr_o <= w_head_wr;
         rf_wd_o <= w_head_wd;
      end else begin
         rf_we_o <= 1'b0;
      end
   end

`ifdef REGARB_STARVE_EN
   localparam logic [1:0] S_STALL = 2'd2;
   localparam logic [7:0] LIM     = 8'(STARVE_LIMIT);

   logic [7:0] r_wait, w_wait_nxt;
   logic       r_stall, w_blocked;

   assign w_blocked = w_nempty && (w_head_wr != 5'd0) && w_busy;

   always_comb begin
      w_wait_nxt = r_wait;
      if (r_state == S_IDLE || w_issue) w_wait_nxt = '0;
      else if (w_blocked && r_wait != LIM) w_wait_nxt = r_wait + 8'd1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_push) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (w_cnt_nxt == '0)        w_state_nxt = S_IDLE;
            else if (w_wait_nxt == LIM) w_state_nxt = S_STALL;
         end
         S_STALL: begin
            if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
            else if (w_issue)    w_state_nxt = S_DRAIN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wait  <= '0;
         r_stall <= 1'b0;
      end else begin
         r_wait  <= w_wait_nxt;
         r_stall <= (w_state_nxt == S_STALL);
      end
   end

   assign stall_req_o = r_stall;
`else
   logic [7:0] w_unused_lim;
   assign w_unused_lim = 8'(STARVE_LIMIT);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_push) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign stall_req_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: constant vector table, directed corner sequences, random vs queue model.
module tb_regfile_wr_arb;
   localparam int D = 2;
   localparam int L = 4;
`ifdef REGARB_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        wb_we_i;
   logic [4:0]  wb_wr_i;
   logic [31:0] wb_wd_i;
   logic        dbg_valid_i;
   logic        dbg_ready_o;
   logic [4:0]  dbg_wr_i;
   logic [31:0] dbg_wd_i;
   logic        rf_we_o;
   logic [4:0]  rf_wr_o;
   logic [31:0] rf_wd_o;
   logic [1:0]  dbg_cnt_o;
   logic        stall_req_o;

   regfile_wr_arb #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .wb_we_i(wb_we_i), .wb_wr_i(wb_wr_i), .wb_wd_i(wb_wd_i),
      .dbg_valid_i(dbg_valid_i), .dbg_ready_o(dbg_ready_o),
      .dbg_wr_i(dbg_wr_i), .dbg_wd_i(dbg_wd_i),
      .rf_we_o(rf_we_o), .rf_wr_o(rf_wr_o), .rf_wd_o(rf_wd_o),
      .dbg_cnt_o(dbg_cnt_o), .stall_req_o(stall_req_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: queue of pending debug writes plus expected output registers
   typedef struct packed { logic [4:0] wr; logic [31:0] wd; } ent_t;
   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_wr;
   logic [31:0] m_wd;
   int          m_wait;
   bit          m_stall;

   task automatic model_reset();
      q.delete();
      m_we = 0; m_wr = 0; m_wd = 0; m_wait = 0; m_stall = 0;
   endtask

   task automatic cyc(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                      input bit dv, input logic [4:0] dwr, input logic [31:0] dwd);
      bit busy, push, issue, pop, blocked;
      wb_we_i = we; wb_wr_i = wr; wb_wd_i = wd;
      dbg_valid_i = dv; dbg_wr_i = dwr; dbg_wd_i = dwd;
      busy = we && (wr != 0);
      push = dv && (q.size() < D);
      issue = 0; pop = 0; blocked = 0;
      if (q.size() > 0) begin
         if (q[0].wr == 0) pop = 1;
         else if (!busy) begin pop = 1; issue = 1; end
         else blocked = 1;
      end
      if (busy) begin m_we = 1; m_wr = wr; m_wd = wd; end
      else if (issue) begin m_we = 1; m_wr = q[0].wr; m_wd = q[0].wd; end
      else m_we = 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{dwr, dwd});
      if (q.size() == 0 || issue) begin m_wait = 0; m_stall = 0; end
      else if (blocked) begin
         if (m_wait < L) m_wait++;
         if (m_wait == L) m_stall = 1;
      end
      @(posedge clk_i); #1;
      chk("rf_we", 32'(rf_we_o), 32'(m_we));
      chk("rf_wr", 32'(rf_wr_o), 32'(m_wr));
      chk("rf_wd", rf_wd_o, m_wd);
      chk("cnt", 32'(dbg_cnt_o), 32'(q.size()));
      chk("ready", 32'(dbg_ready_o), 32'(q.size() < D));
      chk("stall", 32'(stall_req_o), 32'(STARVE_ON && m_stall));
   endtask

   task automatic do_reset();
      reset_i = 1;
      wb_we_i = 0; wb_wr_i = 0; wb_wd_i = 0;
      dbg_valid_i = 0; dbg_wr_i = 0; dbg_wd_i = 0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 reset_i = 0;
      chk("rst_we", 32'(rf_we_o), 0);
      chk("rst_wr", 32'(rf_wr_o), 0);
      chk("rst_wd", rf_wd_o, 0);
      chk("rst_cnt", 32'(dbg_cnt_o), 0);
      chk("rst_ready", 32'(dbg_ready_o), 1);
      chk("rst_stall", 32'(stall_req_o), 0);
   endtask

   typedef struct {
      bit we; logic [4:0] wr; logic [31:0] wd;
      bit dv; logic [4:0] dwr; logic [31:0] dwd;
      bit e_we; logic [4:0] e_wr; logic [31:0] e_wd; logic [1:0] e_cnt; bit e_rdy;
   } vec_t;
   vec_t tbl[11];

   initial begin
      tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 1};
      tbl[1]  = '{0, 0, 0,            0, 0, 0,        0, 5, 32'hDEADBEEF, 0, 1};
      tbl[2]  = '{0, 0, 0,            1, 9, 32'h1234, 0, 5, 32'hDEADBEEF, 1, 1};
      tbl[3]  = '{0, 0, 0,            0, 0, 0,        1, 9, 32'h1234,     0, 1};
      tbl[4]  = '{1, 1, 32'hAAAA,     1, 3, 32'h33,   1, 1, 32'hAAAA,     1, 1};
      tbl[5]  = '{1, 1, 32'hBBBB,     1, 4, 32'h44,   1, 1, 32'hBBBB,     2, 0};
      tbl[6]  = '{1, 1, 32'hCCCC,     1, 5, 32'h55,   1, 1, 32'hCCCC,     2, 0};
      tbl[7]  = '{1, 0, 32'hFFFF,     0, 0, 0,        1, 3, 32'h33,       1, 1};
      tbl[8]  = '{0, 0, 0,            1, 0, 32'h77,   1, 4, 32'h44,       1, 1};
      tbl[9]  = '{1, 2, 32'h2222,     0, 0, 0,        1, 2, 32'h2222,     0, 1};
      tbl[10] = '{0, 0, 0,            0, 0, 0,        0, 2, 32'h2222,     0, 1};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].dv, tbl[i].dwr, tbl[i].dwd);
         chk($sformatf("v%0d_we", i), 32'(rf_we_o), 32'(tbl[i].e_we));
         chk($sformatf("v%0d_wr", i), 32'(rf_wr_o), 32'(tbl[i].e_wr));
         chk($sformatf("v%0d_wd", i), rf_wd_o, tbl[i].e_wd);
         chk($sformatf("v%0d_cnt", i), 32'(dbg_cnt_o), 32'(tbl[i].e_cnt));
         chk($sformatf("v%0d_rdy", i), 32'(dbg_ready_o), 32'(tbl[i].e_rdy));
      end

      // starvation: one queued entry blocked for L cycles
      do_reset();
      cyc(0, 0, 0, 1, 7, 32'h77);
      for (int i = 0; i < L; i++) begin
         cyc(1, 1, 32'(i), 0, 0, 0);
         if (i == L - 2) chk("starve_pre", 32'(stall_req_o), 0);
      end
      chk("starve_hit", 32'(stall_req_o), 32'(STARVE_ON));
      cyc(0, 0, 0, 0, 0, 0);
      chk("starve_issue_we", 32'(rf_we_o), 1);
      chk("starve_issue_wr", 32'(rf_wr_o), 7);
      chk("starve_clear", 32'(stall_req_o), 0);

      // asynchronous reset with two queued entries
      do_reset();
      cyc(1, 1, 32'h11, 1, 8, 32'h88);
      cyc(1, 1, 32'h12, 1, 10, 32'hAA);
      #2 reset_i = 1;
      #1;
      chk("arst_we", 32'(rf_we_o), 0);
      chk("arst_cnt", 32'(dbg_cnt_o), 0);
      chk("arst_ready", 32'(dbg_ready_o), 1);
      model_reset();
      wb_we_i = 0; dbg_valid_i = 0;
      @(posedge clk_i); #1 reset_i = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk("arst_nowr", 32'(rf_we_o), 0);
      end

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         bit we, dv;
         logic [4:0] wr, dwr;
         we  = ($urandom_range(0, 99) < 50);
         if (STARVE_ON && m_stall && $urandom_range(0, 9) < 8) we = 0;
         wr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         dv  = ($urandom_range(0, 99) < 55);
         dwr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         cyc(we, wr, $urandom, dv, dwr, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
